// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bank controller: default sizes, width helpers and byte parity.
// Optional feature macro used by the bank: SRAM_PARITY_EN (per-byte even parity with error flag).
package sram_pkg;

  localparam int unsigned DEF_DATA_W    = 256;
  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned DEF_RD_LAT    = 2;
  localparam int unsigned DEF_RSP_DEPTH = 4;

  // Number of byte lanes in a data word.
  function automatic int unsigned byte_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Response FIFO pointer width; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold 0..depth outstanding reads.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity bit for one byte: XOR of all bits, so data plus parity has an even number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port storage array with byte-masked writes and an RD_LAT-stage read pipeline.
// With SRAM_PARITY_EN defined each byte carries an even-parity bit and reads report mismatches.
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wmask_i,
`ifdef SRAM_PARITY_EN
  input  logic                par_inj_i,
  output logic                rd_err_o,
`endif
  output logic                rd_valid_o,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int unsigned BYTES = byte_count(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef SRAM_PARITY_EN
  // Stored word layout: {parity[BYTES-1:0], data[DATA_W-1:0]}.
  localparam int unsigned STORE_W = DATA_W + BYTES;
`else
  localparam int unsigned STORE_W = DATA_W;
`endif

  logic [STORE_W-1:0] mem_q    [DEPTH];
  logic [STORE_W-1:0] pipe_d_q [RD_LAT];
  logic [RD_LAT-1:0]  pipe_v_q;

  // Byte-masked write; only enabled lanes (and their parity bits) change.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
`ifdef SRAM_PARITY_EN
          // Injection corrupts only byte 0's stored parity, to exercise the error path.
          mem_q[addr_i][DATA_W + b] <= even_parity(wdata_i[8*b +: 8]) ^ ((b == 0) && par_inj_i);
`endif
        end
      end
    end
  end

  // Read pipeline data: stage 0 captures the array word, later stages shift it along.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      pipe_d_q[0] <= mem_q[addr_i];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_d_q[k] <= pipe_d_q[k-1];
    end
  end

  // Read pipeline valid bits; cleared on reset so in-flight reads are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q <= '0;
    end else begin
      pipe_v_q[0] <= rd_en_i;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
      end
    end
  end

  assign rd_valid_o = pipe_v_q[RD_LAT-1];
  assign rd_data_o  = pipe_d_q[RD_LAT-1][DATA_W-1:0];

`ifdef SRAM_PARITY_EN
  // Error flag: any byte whose recomputed parity disagrees with its stored bit.
  always_comb begin
    rd_err_o = 1'b0;
    for (int b = 0; b < BYTES; b++) begin
      if (even_parity(pipe_d_q[RD_LAT-1][8*b +: 8]) != pipe_d_q[RD_LAT-1][DATA_W + b]) begin
        rd_err_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_bank_ctl.sv
// SRAM bank controller: valid/ready request port, credit-limited in-order read response FIFO.
// Optional SRAM_PARITY_EN adds per-byte parity storage, par_inj input and rsp_err output.
module sram_bank_ctl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_we,
  input  logic [ADDR_W-1:0]                  req_addr,
  input  logic [DATA_W-1:0]                  req_wdata,
  input  logic [DATA_W/8-1:0]                req_wmask,
`ifdef SRAM_PARITY_EN
  input  logic                               par_inj,
  output logic                               rsp_err,
`endif
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_W-1:0]                  rsp_rdata,
  output logic [$clog2(RSP_DEPTH+1)-1:0]     rd_outstanding
);

  localparam int unsigned PTR_W = ptr_width(RSP_DEPTH);
  localparam int unsigned CNT_W = credit_width(RSP_DEPTH);

  // Handshake rule for both ports: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and req_ready depends only on registered credit state.

  logic               rd_acc, wr_acc, push, pop;
  logic [DATA_W-1:0]  arr_data;
  logic [CNT_W-1:0]   rd_out_q, rd_out_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  fifo_data_q [RSP_DEPTH];
`ifdef SRAM_PARITY_EN
  logic               arr_err;
  logic [RSP_DEPTH-1:0] fifo_err_q;
`endif

  // Credit check: a read is only taken when a FIFO slot is guaranteed for its data.
  assign req_ready = !rst && (rd_out_q < CNT_W'(RSP_DEPTH));
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign wr_acc    = req_valid && req_ready && req_we;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_acc),
    .rd_en_i    (rd_acc),
    .addr_i     (req_addr),
    .wdata_i    (req_wdata),
    .wmask_i    (req_wmask),
`ifdef SRAM_PARITY_EN
    .par_inj_i  (par_inj),
    .rd_err_o   (arr_err),
`endif
    .rd_valid_o (push),
    .rd_data_o  (arr_data)
  );

  // Next-state for the credit counter and FIFO pointers/occupancy.
  always_comb begin
    rd_out_d   = rd_out_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (rd_acc && !pop) begin
      rd_out_d = rd_out_q + CNT_W'(1);
    end else if (pop && !rd_acc) begin
      rd_out_d = rd_out_q - CNT_W'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Control state registers; reset discards all queued responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_out_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rd_out_q   <= rd_out_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO payload storage; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= arr_data;
    end
  end

`ifdef SRAM_PARITY_EN
  // Parity error flag travels with its data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_err_q <= '0;
    end else if (push) begin
      fifo_err_q[wr_ptr_q] <= arr_err;
    end
  end

  assign rsp_err = rsp_valid && fifo_err_q[rd_ptr_q];
`endif

  // Head is gated so rsp_rdata reads zero whenever no response is present.
  assign rsp_rdata      = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rd_outstanding = rd_out_q;

endmodule
